rocket_bfm_msg_arb: RTL and testbench

- Round-robin, packet-locking arbiter that shares one testbench-to-host message channel among the per-core RocketBFM instances bound into each Rocket tile.
- Each BFM streams multi-beat messages (valid/ready/last). The arbiter grants one core at a time and holds the grant until that core's last beat is accepted.
- Tags every output beat with the source core index.
- A stall watchdog reclaims the channel from a core that stops mid-packet.

---
 rtl/rocket_bfm_arb_pkg.sv | 13 +
 rtl/rocket_bfm_rr_pick.sv | 28 ++
 rtl/rocket_bfm_msg_arb.sv | 108 ++++++++++
 tb/tb_rocket_bfm_msg_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocket_bfm_arb_pkg.sv
// Shared types and constants for the RocketBFM message-channel arbiter.
package rocket_bfm_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;

  localparam int PKT_CNT_W = 16;

  // A single requester still needs a one-bit source index.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rocket_bfm_rr_pick.sv
// Rotating-priority picker: returns the first asserted request after ptr, wrapping modulo N_REQ.
module rocket_bfm_rr_pick
  import rocket_bfm_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int SRC_W = src_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic             found,
  output logic [SRC_W-1:0] index
);

  always_comb begin : pick
    logic [SRC_W-1:0] cand;
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = SRC_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/rocket_bfm_msg_arb.sv
// Packet-locking round-robin arbiter sharing one message channel among per-core RocketBFMs,
// with a stall watchdog that reclaims the channel from a requester that stops mid-packet.
module rocket_bfm_msg_arb
  import rocket_bfm_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  localparam int SRC_W  = src_width(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        en_mask,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    msg_valid,
  output logic [DATA_W-1:0]       msg_data,
  output logic                    msg_last,
  output logic [SRC_W-1:0]        msg_src,
  input  logic                    msg_ready,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [SRC_W-1:0]        err_src,
  output logic [PKT_CNT_W-1:0]    pkt_count
);

  arb_state_e       state;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] grant;
  logic [31:0]      stall_cnt;
  logic             pick_found;
  logic [SRC_W-1:0] pick_idx;

  // Enables only matter at arbitration time; once granted, the mask is ignored.
  rocket_bfm_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_valid & en_mask),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    msg_valid = 1'b0;
    msg_data  = '0;
    msg_last  = 1'b0;
    msg_src   = '0;
    busy      = (state == BUSY);
    if (state == BUSY) begin
      msg_src = grant;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant == SRC_W'(i)) begin
          msg_valid    = req_valid[i];
          msg_data     = req_data[i*DATA_W +: DATA_W];
          msg_last     = req_last[i];
          req_ready[i] = msg_ready;
        end
      end
    end
  end

  // Backpressure with valid data is not a stall; only an absent beat advances the watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= SRC_W'(N_REQ - 1);
      grant       <= '0;
      stall_cnt   <= '0;
      pkt_count   <= '0;
      err_src     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant     <= pick_idx;
            state     <= BUSY;
            stall_cnt <= '0;
          end
        end
        BUSY: begin
          if (msg_valid) begin
            stall_cnt <= '0;
            if (msg_ready && msg_last) begin
              state     <= IDLE;
              ptr       <= grant;
              pkt_count <= pkt_count + 16'd1;
            end
          end else if (TIMEOUT != 0) begin
            if (stall_cnt == 32'(TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              err_src     <= grant;
              state       <= IDLE;
              ptr         <= grant;
            end else begin
              stall_cnt <= stall_cnt + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rocket_bfm_msg_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_rocket_bfm_msg_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     en_mask, req_valid, req_last, req_ready;
  logic [N*W-1:0]   req_data;
  logic [W-1:0]     data_arr [N];
  logic             msg_valid, msg_last, msg_ready, busy, timeout_err;
  logic [W-1:0]     msg_data;
  logic [1:0]       msg_src, err_src;
  logic [15:0]      pkt_count;

  int total = 0;
  int bad   = 0;

  int         m_owner    = -1;
  int         m_last_win = N - 1;
  int         m_stalls   = 0;
  int         m_pkts     = 0;
  int         m_err_src  = 0;
  bit         m_terr     = 0;
  bit         m_known    = 0;
  logic [N-1:0] m_accept;

  logic         s_valid, s_last, s_busy, s_terr;
  logic [W-1:0] s_data;
  logic [1:0]   s_src, s_esrc;
  logic [15:0]  s_pkts;
  logic [N-1:0] s_ready;

  int           src_q[$];
  logic [W-1:0] got_q[$];
  int           exp_fair[6] = '{0, 1, 2, 3, 0, 1};
  int           exp_mask[4] = '{1, 3, 1, 3};
  int           terr_k[21], esrc_k[21], src_k[21], valid_k[21], pkts_k[21];
  int           fired_at, idx;
  bit           saw_terr;
  logic [3:0]   pat;
  int           rem[N], seq[N];
  logic [N-1:0] rv, rl, ren;
  logic [W-1:0] rd[N];
  int           drop;

  rocket_bfm_msg_arb #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .en_mask     (en_mask),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .msg_valid   (msg_valid),
    .msg_data    (msg_data),
    .msg_last    (msg_last),
    .msg_src     (msg_src),
    .msg_ready   (msg_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_src     (err_src),
    .pkt_count   (pkt_count)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*W +: W] = data_arr[i];
  end

  task automatic checkField(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: one granted owner at a time, round-robin from the last finisher or timed-out owner.
  task automatic modelStep();
    logic [1:0] ci;
    logic [1:0] gi;
    bit         hit;
    if (reset) begin
      m_owner = -1; m_last_win = N - 1; m_stalls = 0; m_pkts = 0;
      m_err_src = 0; m_terr = 0; m_known = 1;
      return;
    end
    m_terr = 0;
    if (m_owner < 0) begin
      hit = 0;
      for (int k = 1; k <= N; k++) begin
        ci = 2'((m_last_win + k) % N);
        if (!hit && req_valid[ci] && en_mask[ci]) begin
          hit = 1; m_owner = int'(ci); m_stalls = 0;
        end
      end
    end else begin
      gi = 2'(m_owner);
      if (req_valid[gi]) begin
        m_stalls = 0;
        if (msg_ready && req_last[gi]) begin
          m_pkts = (m_pkts + 1) % 65536;
          m_last_win = m_owner;
          m_owner = -1;
        end
      end else if (TO != 0) begin
        if (m_stalls == TO - 1) begin
          m_terr = 1; m_err_src = m_owner; m_last_win = m_owner; m_owner = -1;
        end else begin
          m_stalls++;
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic         ev, el;
    logic [W-1:0] ed;
    logic [N-1:0] er;
    logic [1:0]   gi;
    #1;
    s_valid = msg_valid; s_last = msg_last; s_busy = busy; s_terr = timeout_err;
    s_data = msg_data; s_src = msg_src; s_esrc = err_src; s_pkts = pkt_count; s_ready = req_ready;
    gi = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    if (m_known) begin
      ev = 0; el = 0; ed = '0; er = '0;
      if (m_owner >= 0) begin
        ev = req_valid[gi]; el = req_last[gi]; ed = data_arr[gi];
        er[gi] = msg_ready;
      end
      checkField("msg_valid", s_valid, ev);
      checkField("msg_last", s_last, el);
      checkField("msg_data", s_data, ed);
      checkField("msg_src", s_src, gi);
      checkField("req_ready", s_ready, er);
      checkField("busy", s_busy, m_owner >= 0);
      checkField("timeout_err", s_terr, m_terr);
      checkField("err_src", s_esrc, m_err_src);
      checkField("pkt_count", s_pkts, m_pkts);
    end
    m_accept = '0;
    if (m_owner >= 0 && !reset && req_valid[gi] && msg_ready) m_accept[gi] = 1'b1;
    modelStep();
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] en, input logic [N-1:0] v,
                               input logic [N-1:0] l, input logic rdy, input logic [W-1:0] d0,
                               input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [W-1:0] d3);
    @(negedge clock);
    reset = rst; en_mask = en; req_valid = v; req_last = l; msg_ready = rdy;
    data_arr[0] = d0; data_arr[1] = d1; data_arr[2] = d2; data_arr[3] = d3;
    checkOutput();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    reset = 1; en_mask = '0; req_valid = '0; req_last = '0; msg_ready = 0;
    for (int i = 0; i < N; i++) data_arr[i] = '0;
    applyStimulus(1, 4'hF, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 4'hF, 0, 0, 1, 0, 0, 0, 0);

    $display("[TB] single requester packet");
    applyStimulus(0, 4'hF, 4'b0100, 0, 1, 0, 0, 32'hA0, 0);
    checkField("t1_arb_valid", s_valid, 0);
    checkField("t1_arb_busy", s_busy, 0);
    applyStimulus(0, 4'hF, 4'b0100, 0, 1, 0, 0, 32'hA0, 0);
    checkField("t1_b0_valid", s_valid, 1);
    checkField("t1_b0_src", s_src, 2);
    checkField("t1_b0_data", s_data, 32'hA0);
    checkField("t1_b0_ready", s_ready, 4'b0100);
    applyStimulus(0, 4'hF, 4'b0100, 0, 1, 0, 0, 32'hA1, 0);
    checkField("t1_b1_data", s_data, 32'hA1);
    applyStimulus(0, 4'hF, 4'b0100, 4'b0100, 1, 0, 0, 32'hA2, 0);
    checkField("t1_b2_data", s_data, 32'hA2);
    checkField("t1_b2_last", s_last, 1);
    applyStimulus(0, 4'hF, 0, 0, 1, 0, 0, 0, 0);
    checkField("t1_after_busy", s_busy, 0);
    checkField("t1_after_pkts", s_pkts, 1);

    $display("[TB] fairness");
    applyStimulus(1, 4'hF, 0, 0, 1, 0, 0, 0, 0);
    src_q.delete();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(0, 4'hF, 4'hF, 4'hF, 1, 32'h10, 32'h11, 32'h12, 32'h13);
      if (s_valid) src_q.push_back(int'(s_src));
    end
    checkField("t2_grants", src_q.size(), 6);
    for (int i = 0; i < 6 && i < src_q.size(); i++) checkField("t2_src_seq", src_q[i], exp_fair[i]);
    applyStimulus(0, 4'hF, 0, 0, 1, 0, 0, 0, 0);
    checkField("t2_pkts", s_pkts, 6);

    $display("[TB] backpressure");
    applyStimulus(1, 4'hF, 0, 0, 1, 0, 0, 0, 0);
    pat = 4'b1001; idx = 0; saw_terr = 0; got_q.delete();
    for (int c = 0; c < 40 && idx < 4; c++) begin
      applyStimulus(0, 4'hF, 4'b0010, (idx == 3) ? 4'b0010 : 4'b0000, pat[c % 4],
                    0, 32'hB0 + 32'(idx), 0, 0);
      if (s_terr) saw_terr = 1;
      if (s_valid && msg_ready) begin
        got_q.push_back(s_data);
        idx++;
      end
    end
    checkField("t3_beats", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) checkField("t3_beat_data", got_q[i], 32'hB0 + 32'(i));
    checkField("t3_no_timeout", saw_terr, 0);

    $display("[TB] watchdog");
    applyStimulus(1, 4'hF, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 4'hF, 4'b1000, 0, 1, 0, 0, 0, 32'hC0);
    applyStimulus(0, 4'hF, 4'b1000, 0, 1, 0, 0, 0, 32'hC0);
    checkField("t4_beat_src", s_src, 3);
    fired_at = -1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(0, 4'hF, 4'b0001, 4'b0001, 1, 32'h50, 0, 0, 0);
      terr_k[k] = int'(s_terr); esrc_k[k] = int'(s_esrc); src_k[k] = int'(s_src);
      valid_k[k] = int'(s_valid); pkts_k[k] = int'(s_pkts);
      if (s_terr && fired_at < 0) fired_at = k;
    end
    checkField("t4_fire_cycle", fired_at, 9);
    checkField("t4_err_src", esrc_k[9], 3);
    checkField("t4_pulse_width", terr_k[10], 0);
    checkField("t4_pkts_at_fire", pkts_k[10], 0);
    checkField("t4_next_valid", valid_k[10], 1);
    checkField("t4_next_src", src_k[10], 0);

    $display("[TB] enable mask");
    applyStimulus(1, 4'hF, 0, 0, 1, 0, 0, 0, 0);
    src_q.delete();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 4'b1010, 4'hF, 4'hF, 1, 32'h20, 32'h21, 32'h22, 32'h23);
      if (s_valid) src_q.push_back(int'(s_src));
    end
    checkField("t5_grants", src_q.size(), 4);
    for (int i = 0; i < 4 && i < src_q.size(); i++) checkField("t5_src_seq", src_q[i], exp_mask[i]);
    applyStimulus(0, 4'b0010, 4'b0010, 0, 1, 0, 32'hD0, 0, 0);
    checkField("t5_arb_valid", s_valid, 0);
    for (int b = 0; b < 3; b++) begin
      applyStimulus(0, 4'b0000, 4'b0010, (b == 2) ? 4'b0010 : 4'b0000, 1, 0, 32'hD0 + 32'(b), 0, 0);
      checkField("t5_masked_valid", s_valid, 1);
      checkField("t5_masked_data", s_data, 32'hD0 + 32'(b));
    end
    applyStimulus(0, 4'b0000, 0, 0, 1, 0, 0, 0, 0);
    checkField("t5_pkts", s_pkts, 5);
    checkField("t5_busy", s_busy, 0);

    $display("[TB] reset mid-packet");
    applyStimulus(0, 4'hF, 4'b0100, 0, 1, 0, 0, 32'hE0, 0);
    applyStimulus(0, 4'hF, 4'b0100, 0, 1, 0, 0, 32'hE0, 0);
    applyStimulus(1, 4'hF, 4'b0100, 0, 1, 0, 0, 32'hE1, 0);
    applyStimulus(0, 4'hF, 4'b1001, 4'b1001, 1, 32'h60, 0, 0, 32'h63);
    checkField("t6_valid", s_valid, 0);
    checkField("t6_busy", s_busy, 0);
    checkField("t6_pkts", s_pkts, 0);
    applyStimulus(0, 4'hF, 4'b1001, 4'b1001, 1, 32'h60, 0, 0, 32'h63);
    checkField("t6_next_src", s_src, 0);
    checkField("t6_next_data", s_data, 32'h60);

    $display("[TB] randomized traffic");
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      drop = (c < 1500) ? 10 : 45;
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && ($urandom % 3) == 0) rem[i] = 1 + int'($urandom % 5);
        rv[i] = (rem[i] > 0) && ($urandom_range(0, 99) >= drop);
        rl[i] = (rem[i] == 1);
        rd[i] = {8'(i), 24'(seq[i])};
      end
      ren = (($urandom % 8) == 0) ? 4'($urandom) : 4'hF;
      applyStimulus(($urandom % 700) == 0, ren, rv, rl, ($urandom % 4) != 0,
                    rd[0], rd[1], rd[2], rd[3]);
      for (int i = 0; i < N; i++) begin
        if (m_accept[i]) begin
          rem[i]--;
          seq[i]++;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
